// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte stream handshake between the UART receiver (master) and its consumer
// (slave). Single-entry, AXI-Stream style: a byte moves on a clock edge where
// tvalid and tready are both high.
//
// Signals
//   tvalid  master -> slave  tdata holds an unconsumed byte
//   tready  slave  -> master consumer can take the byte this cycle
//   tdata   master -> slave  received byte, bit 0 = first data bit on the wire
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_rx_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART serial receiver, 8N1 framing, LSB first, idle-high line. The bit period
// is a fixed number of clock cycles. Each received byte is held in a
// single-entry output register and offered on a stream master port. If a new
// byte completes while the previous one is still unconsumed, the new byte
// replaces it and overflow pulses for one cycle.
//
// Parameters
//   cycles_per_bit  clk cycles per serial bit (434 = 50 MHz / 115200 baud), >= 4
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous, active-high reset
//   rx        in   serial input (already synchronised), idle = 1, start = 0
//   m_axis    --   uart_rx_if.master: tvalid / tready / tdata byte stream
//   overflow  out  one-cycle pulse: a byte completed while tvalid=1 and the
//                  old byte was not consumed on that edge
//
// Build option
//   UART_RX_FRAMING_CHECK_EN  when defined, a frame whose stop-bit sample is 0
//                             is discarded. When undefined, the stop-bit value
//                             is ignored and the byte is always delivered.
//                             Either way the receiver waits for rx=1 before
//                             it re-arms in IDLE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
  parameter int cycles_per_bit = 434
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master m_axis,
  output logic      overflow
);

  // One extra bit of headroom so the counter can never wrap within a period.
  localparam int cnt_w = $clog2(cycles_per_bit) + 1;

  // Terminal counts: the cycle on which the counter reaches these values is
  // the cycle on which rx is sampled.
  localparam logic [cnt_w-1:0] half_last = cnt_w'(cycles_per_bit / 2 - 1);
  localparam logic [cnt_w-1:0] full_last = cnt_w'(cycles_per_bit - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t           state, state_n;
  logic [cnt_w-1:0] cnt, cnt_n;          // cycles elapsed in the current bit
  logic [2:0]       bit_idx, bit_idx_n;  // next data bit to capture
  logic [7:0]       shift, shift_n;      // data bits assembled so far
  logic             stop_wait, stop_wait_n; // stop sampled low, waiting for rx=1
  logic             accept;              // frame complete and delivered this cycle
  logic             stop_ok;             // stop-bit sample allows delivery

  // Output register
  logic             tvalid_q;
  logic [7:0]       tdata_q;
  logic             overflow_q;
  logic             handshake;

`ifdef UART_RX_FRAMING_CHECK_EN
  // A low stop bit marks a framing error; the byte is dropped.
  assign stop_ok = rx;
`else
  // Stop-bit value does not gate delivery.
  assign stop_ok = 1'b1;
`endif

  assign handshake = tvalid_q & m_axis.tready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    stop_wait_n = stop_wait;
    accept      = 1'b0;

    case (state)
      IDLE: begin
        // Level-sensitive start detection: any low sample arms the receiver,
        // no falling edge is required.
        if (!rx) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        // Re-check the line at the middle of the start bit; a high level
        // there means the low pulse was a glitch.
        if (cnt == half_last) begin
          cnt_n     = '0;
          bit_idx_n = 3'd0;
          state_n   = rx ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DATA: begin
        // One full period after the previous sample lands mid-bit again.
        if (cnt == full_last) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STOP: begin
        if (stop_wait) begin
          // Line must return high before re-arming, otherwise a low stop bit
          // (or a low bit 7 running into it) would look like a new start.
          if (rx) begin
            stop_wait_n = 1'b0;
            state_n     = IDLE;
          end
        end else if (cnt == full_last) begin
          cnt_n  = '0;
          accept = stop_ok;
          if (rx) begin
            state_n = IDLE;
          end else begin
            stop_wait_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        cnt_n       = '0;
        stop_wait_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      stop_wait <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      stop_wait <= stop_wait_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // A new byte always wins: it is loaded whether or not the old one is taken
  // on the same edge. Only an untaken old byte counts as an overflow.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q   <= 1'b0;
      tdata_q    <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (accept) begin
        tdata_q    <= shift;
        tvalid_q   <= 1'b1;
        overflow_q <= tvalid_q & ~m_axis.tready;
      end else if (handshake) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign overflow      = overflow_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 50 MHz, 115200 baud (434 cycles per bit).
// Frames are driven as timed serial waveforms. A behavioural model of the
// single-entry output register (byte queue plus one held slot) predicts the
// delivered byte stream and the overflow count; a monitor records what the
// DUT actually hands over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB    = 434;
  localparam int CLK_NS = 20;
  localparam int BIT_NS = CPB * CLK_NS;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic overflow;

  uart_rx_if bus ();

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .m_axis   (bus),
    .overflow (overflow)
  );

  always #(CLK_NS / 2) clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];   // bytes the model says the consumer receives
  logic [7:0] got_q[$];   // bytes the DUT handed over
  logic       held_valid = 1'b0;
  logic [7:0] held_data  = 8'h00;
  int         exp_ovf    = 0;

  int   ovf_cnt   = 0;    // cycles with overflow high
  int   valid_cnt = 0;    // cycles with tvalid high
  int   stuck_cnt = 0;    // tvalid still high the cycle after a handshake
  logic prev_hs   = 1'b0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.tvalid && bus.tready) got_q.push_back(bus.tdata);
      if (overflow === 1'b1) ovf_cnt++;
      if (bus.tvalid === 1'b1) valid_cnt++;
      if (prev_hs && bus.tvalid === 1'b1) stuck_cnt++;
      prev_hs = bus.tvalid && bus.tready;
    end else begin
      prev_hs = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial waveform: start, 8 data bits LSB first, stop, then idle high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
    rx = 1'b1;
  endtask

  // Reference model of the output slot for one delivered frame.
  task automatic model_accept(input logic [7:0] b);
    if (bus.tready) begin
      exp_q.push_back(b);
    end else begin
      if (held_valid) exp_ovf++;
      held_valid = 1'b1;
      held_data  = b;
    end
  endtask

  task automatic set_ready(input logic r);
    @(negedge clk);
    bus.tready = r;
    if (r && held_valid) begin
      exp_q.push_back(held_data);
      held_valid = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  // Compare and drain both byte streams, then the side-band counters.
  task automatic check_stream(input string tag);
    int n;
    check({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, " overflow"}, ovf_cnt, exp_ovf);
    check({tag, " tvalid drop"}, stuck_cnt, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    int         valid_snap;
    logic [7:0] b;
    logic       r;

    rst        = 1'b1;
    rx         = 1'b1;
    bus.tready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tvalid", bus.tvalid, 1'b0);
    check("reset tdata", bus.tdata, 8'h00);
    check("reset overflow", overflow, 1'b0);
    rst = 1'b0;

    // Line held low briefly with no frame: receiver must not deliver.
    @(negedge clk);
    rx = 1'b0;
    #100;
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("low pulse tvalid", valid_cnt, 0);

    // Single byte, consumer always ready.
    set_ready(1'b1);
    send_frame(8'h4D, 1'b1);
    model_accept(8'h4D);
    settle();
    check_stream("byte77");

    // Two bytes with the consumer stalled: second overwrites and overflows.
    set_ready(1'b0);
    send_frame(8'h4D, 1'b1);
    model_accept(8'h4D);
    settle();
    check("stall1 overflow", ovf_cnt, exp_ovf);
    check("stall1 tvalid", bus.tvalid, 1'b1);
    check("stall1 tdata", bus.tdata, 8'h4D);
    send_frame(8'h4D, 1'b1);
    model_accept(8'h4D);
    settle();
    check("stall2 overflow", ovf_cnt, exp_ovf);
    check("stall2 tvalid", bus.tvalid, 1'b1);
    check("stall2 tdata", held_data, bus.tdata);
    set_ready(1'b1);
    check_stream("stall");

    // Back-to-back 0x00 then 0xFF; low bit 7 must not start a phantom frame.
    send_frame(8'h00, 1'b1);
    model_accept(8'h00);
    send_frame(8'hFF, 1'b1);
    model_accept(8'hFF);
    settle();
    check_stream("b2b");

    // Reset in bit 4 with a byte already held: both are discarded.
    set_ready(1'b0);
    send_frame(8'h5A, 1'b1);
    model_accept(8'h5A);
    settle();
    check("held before rst", bus.tvalid, 1'b1);
    valid_snap = 0;
    @(negedge clk);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        held_valid = 1'b0;
        check("rst tvalid", bus.tvalid, 1'b0);
        valid_snap = valid_cnt;
      end
    join
    settle();
    check("post rst no byte", valid_cnt, valid_snap);
    set_ready(1'b1);
    send_frame(8'h96, 1'b1);
    model_accept(8'h96);
    settle();
    check_stream("after rst");

    // Frame with a low stop bit.
    send_frame(8'hA5, 1'b0);
`ifdef UART_RX_FRAMING_CHECK_EN
    // Framing error: nothing delivered.
`else
    model_accept(8'hA5);
`endif
    settle();
    check_stream("bad stop");

    // Randomized bytes with randomized consumer stalls.
    for (int k = 0; k < 6; k++) begin
      r = 1'($urandom_range(0, 1));
      set_ready(r);
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_accept(b);
      settle();
      if (held_valid) begin
        check($sformatf("rand%0d tvalid", k), bus.tvalid, 1'b1);
        check($sformatf("rand%0d tdata", k), bus.tdata, held_data);
      end
    end
    set_ready(1'b1);
    settle();
    check_stream("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
